// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
// The bus master reuses the R/W and ACK constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Two-wire bus as seen by the target.
// SDA_OE is open-drain: 1 pulls SDA low and 0 releases it.
interface i2c_target_if;
    logic SCL_IN;
    logic SDA_IN;
    logic SDA_OE;

    modport slave  (input SCL_IN, input SDA_IN, output SDA_OE);
    modport master (output SCL_IN, output SDA_IN, input SDA_OE);
endinterface

// File: rtl/i2c_line_filter.sv
// Bus line conditioning: a 2-FF synchroniser, a 3-sample majority vote and registered edge flags.
// An input step reaches rise_o/fall_o 4 clocks later. Single-clock glitches never reach the output.
module i2c_line_filter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;
    logic       maj;

    assign maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

    // Reset to the idle-high bus level so that reset itself produces no edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            hist_q  <= 2'b11;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            hist_q  <= {hist_q[0], sync_q[1]};
            level_q <= maj;
            rise_q  <= maj & ~level_q;
            fall_q  <= ~maj & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target that exposes a byte-wide register file to an I2C master.
// A host port on the same clock preloads the register file and reads it back.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         ADDR_W   = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    i2c_target_if.slave       bus,
    input  logic              REG_WE,
    input  logic [ADDR_W-1:0] REG_A,
    input  logic [7:0]        REG_WD,
    output logic [7:0]        REG_RD,
    output logic              BUSY,
    output logic              WR_EVT,
    output i2c_state_e        dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_evt_q, wr_evt_d;
    logic [7:0]        reg_rd_q;
    logic              commit;
    logic [7:0]        rd_byte;

    i2c_line_filter u_scl (.clk_i(CLK), .rst_i(RESET), .line_i(bus.SCL_IN),
                           .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
    i2c_line_filter u_sda (.clk_i(CLK), .rst_i(RESET), .line_i(bus.SDA_IN),
                           .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rd_byte   = mem[ptr_q];

    // SDA only moves on SCL falling edges, so the target can never fake a START or STOP.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_evt_d  = 1'b0;
        commit    = 1'b0;
        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR: if (bit_cnt_q == 4'd8) begin
                    if (shift_q[7:1] == DEV_ADDR) begin
                        state_d  = ST_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shift_q[0];
                    end else begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_d = '0;
                    if (rw_q == I2C_RW_READ) begin
                        state_d  = ST_RDATA;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        ptr_d    = ptr_q + 1'b1;
                    end else begin
                        state_d  = ST_PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_PTR: if (bit_cnt_q == 4'd8) begin
                    ptr_d    = shift_q[ADDR_W-1:0];
                    state_d  = ST_PTR_ACK;
                    sda_oe_d = 1'b1;
                end
                ST_PTR_ACK: begin
                    state_d   = ST_WDATA;
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                end
                ST_WDATA: if (bit_cnt_q == 4'd8) begin
                    state_d  = ST_WDATA_ACK;
                    sda_oe_d = 1'b1;
                end
                ST_WDATA_ACK: begin
                    commit    = 1'b1;
                    wr_evt_d  = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                    state_d   = ST_WDATA;
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                end
                ST_RDATA: if (bit_cnt_q == 4'd8) begin
                    state_d  = ST_RDATA_ACK;
                    sda_oe_d = 1'b0;
                end else begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                end
                ST_RDATA_ACK: if (ack_q == I2C_ACK) begin
                    state_d   = ST_RDATA;
                    shift_d   = rd_byte;
                    sda_oe_d  = ~rd_byte[7];
                    ptr_d     = ptr_q + 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    state_d  = ST_IGNORE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
                default: ;
            endcase
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: if (bit_cnt_q != 4'd8) begin
                    shift_d   = {shift_q[6:0], sda_lvl};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                ST_RDATA: if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                ST_RDATA_ACK: ack_d = sda_lvl;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= I2C_NACK;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_evt_q  <= 1'b0;
            reg_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_evt_q  <= wr_evt_d;
            reg_rd_q  <= mem[REG_A];
        end
    end

    // The host write comes second, so it wins an address collision with an I2C commit.
    always_ff @(posedge CLK) begin
        if (commit && !RESET) mem[ptr_q] <= shift_q;
        if (REG_WE)           mem[REG_A] <= REG_WD;
    end

    assign bus.SDA_OE  = sda_oe_q;
    assign BUSY        = busy_q;
    assign WR_EVT      = wr_evt_q;
    assign REG_RD      = reg_rd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master on a wired-AND SDA, host-port vectors and a byte scoreboard.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0;
    logic       reg_we;
    logic [4:0] reg_a;
    logic [7:0] reg_wd, reg_rd;
    logic       busy, wr_evt;
    i2c_state_e dbg_state;

    i2c_target_if bus();
    assign bus.SCL_IN = scl_m;
    assign bus.SDA_IN = sda_m & ~bus.SDA_OE & ~glitch;

    i2c_target #(.DEV_ADDR(7'h68), .ADDR_W(5)) dut (
        .CLK(clk), .RESET(rst), .bus(bus),
        .REG_WE(reg_we), .REG_A(reg_a), .REG_WD(reg_wd), .REG_RD(reg_rd),
        .BUSY(busy), .WR_EVT(wr_evt), .dbg_state_o(dbg_state)
    );

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
    } hvec_t;

    int         checks = 0, errors = 0;
    int         evt_cnt = 0;
    int         evt_lat = 0;
    int         coll_at = 0;
    logic       oe_seen = 1'b0, busy_seen = 1'b0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (wr_evt) evt_cnt++;
        if (bus.SDA_OE) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name, input logic [7:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <empty queue>", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
        end
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic write_bit(input logic b, input bit g);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        if (g) begin
            glitch = 1'b1; wait_clk(1);
            glitch = 1'b0; wait_clk(Q - 1);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = bus.SDA_IN; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // The coll flag pulses a host write to reg[5] in the clock that the commit lands.
    task automatic write_byte(input logic [7:0] d, input int glitch_bit, input bit coll, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], (7 - i) == glitch_bit);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = ~bus.SDA_IN; wait_clk(Q);
        scl_m = 1'b0;
        for (int i = 1; i <= Q; i++) begin
            if (coll && i == coll_at) begin
                reg_we = 1'b1; reg_a = 5'd5; reg_wd = 8'h55;
            end else begin
                reg_we = 1'b0;
            end
            @(negedge clk);
            if (wr_evt && !coll) evt_lat = i;
        end
        reg_we = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack, 1'b0);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_a = a; reg_wd = d;
        wait_clk(1);
        reg_we = 1'b0;
    endtask

    task automatic host_read_check(input string name, input logic [4:0] a);
        reg_a = a;
        wait_clk(2);
        check_pop(name, reg_rd);
    endtask

    initial begin
        hvec_t      tbl[6];
        logic       ack;
        logic [7:0] d;
        int         base;

        rst = 1'b1; reg_we = 1'b0; reg_a = '0; reg_wd = '0;
        wait_clk(4);
        check("reset_sda_oe", bus.SDA_OE, 0);
        check("reset_busy", busy, 0);
        check("reset_wr_evt", wr_evt, 0);
        check("reset_reg_rd", reg_rd, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        wait_clk(4);

        // Host port vectors: the written value must show on REG_RD two clocks after REG_WE.
        for (int i = 0; i < 6; i++) begin
            tbl[i].a      = 5'(16 + i);
            tbl[i].wd     = 8'($urandom_range(0, 255));
            tbl[i].exp_rd = tbl[i].wd;
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(tbl[i].exp_rd);
            host_write(tbl[i].a, tbl[i].wd);
            wait_clk(1);
            check_pop($sformatf("host_vec%0d", i), reg_rd);
        end

        // Pointer write followed by a burst write.
        base = evt_cnt;
        i2c_start();
        write_byte(8'hD0, -1, 1'b0, ack); check("t1_addr_ack", ack, 1);
        check("t1_busy_high", busy, 1);
        write_byte(8'h03, -1, 1'b0, ack); check("t1_ptr_ack", ack, 1);
        write_byte(8'hAA, -1, 1'b0, ack); check("t1_d0_ack", ack, 1);
        write_byte(8'hBB, -1, 1'b0, ack); check("t1_d1_ack", ack, 1);
        i2c_stop();
        check("t1_busy_low", busy, 0);
        check("t1_wr_evt_count", evt_cnt - base, 2);
        exp_q.push_back(8'hAA); host_read_check("t1_reg3", 5'd3);
        exp_q.push_back(8'hBB); host_read_check("t1_reg4", 5'd4);

        // Pointer write, repeated START, then a two-byte read that wraps the pointer.
        host_write(5'h1F, 8'h11);
        host_write(5'h00, 8'h22);
        i2c_start();
        write_byte(8'hD0, -1, 1'b0, ack); check("t2_addr_ack", ack, 1);
        write_byte(8'h1F, -1, 1'b0, ack); check("t2_ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'hD1, -1, 1'b0, ack); check("t2_raddr_ack", ack, 1);
        exp_q.push_back(8'h11); read_byte(1'b0, d); check_pop("t2_byte0", d);
        exp_q.push_back(8'h22); read_byte(1'b1, d); check_pop("t2_byte1", d);
        check("t2_sda_released", bus.SDA_OE, 0);
        check("t2_state_ignore", dbg_state, ST_IGNORE);
        check("t2_busy_low", busy, 0);
        i2c_stop();

        // Address mismatch: the target must stay fully silent.
        base = evt_cnt;
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, -1, 1'b0, ack); check("t3_no_ack", ack, 0);
        write_byte(8'h03, -1, 1'b0, ack);
        i2c_stop();
        check("t3_oe_never", oe_seen, 0);
        check("t3_busy_never", busy_seen, 0);
        check("t3_no_wr_evt", evt_cnt - base, 0);
        exp_q.push_back(8'hAA); host_read_check("t3_reg3_kept", 5'd3);

        // Host write and I2C commit to reg[5] land in the same clock.
        base = evt_cnt;
        coll_at = evt_lat;
        i2c_start();
        write_byte(8'hD0, -1, 1'b0, ack); check("t4_addr_ack", ack, 1);
        write_byte(8'h05, -1, 1'b0, ack); check("t4_ptr_ack", ack, 1);
        write_byte(8'h66, -1, 1'b1, ack); check("t4_data_ack", ack, 1);
        i2c_stop();
        check("t4_wr_evt", evt_cnt - base, 1);
        exp_q.push_back(8'h55); host_read_check("t4_host_wins", 5'd5);

        // Reset pulsed while the target drives a 0 data bit.
        host_write(5'd7, 8'h3C);
        i2c_start();
        write_byte(8'hD0, -1, 1'b0, ack); check("t5_addr_ack", ack, 1);
        write_byte(8'h07, -1, 1'b0, ack); check("t5_ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'hD1, -1, 1'b0, ack); check("t5_raddr_ack", ack, 1);
        check("t5_driving_zero", bus.SDA_OE, 1);
        rst = 1'b1; wait_clk(1); rst = 1'b0;
        check("t5_oe_cleared", bus.SDA_OE, 0);
        check("t5_state_idle", dbg_state, ST_IDLE);
        check("t5_busy_cleared", busy, 0);
        check("t5_reg_rd_cleared", reg_rd, 0);
        wait_clk(Q);
        i2c_start();
        write_byte(8'hD1, -1, 1'b0, ack); check("t5_after_addr_ack", ack, 1);
        exp_q.push_back(8'h22); read_byte(1'b1, d); check_pop("t5_reg0", d);
        i2c_stop();

        // One-clock low glitch on SDA while SCL is high inside a data byte.
        base = evt_cnt;
        i2c_start();
        write_byte(8'hD0, -1, 1'b0, ack); check("t6_addr_ack", ack, 1);
        write_byte(8'h08, -1, 1'b0, ack); check("t6_ptr_ack", ack, 1);
        write_byte(8'h5A, 3, 1'b0, ack); check("t6_data_ack", ack, 1);
        i2c_stop();
        check("t6_wr_evt", evt_cnt - base, 1);
        exp_q.push_back(8'h5A); host_read_check("t6_reg8", 5'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
